axi4lite_dpc_cfg_bank: RTL and testbench

// - Parametrised AXI4-Lite slave for DPC blocks: 4 control/status words plus a byte-strobed bad-pixel LUT window.
// - Sits between the PS interconnect and the detector/corrector cores.
// - Improvements: independent AW/W acceptance, SLVERR decode, write-1-to-clear (W1C) sticky status,

---
 rtl/axi4lite_dpc_cfg_bank_if.sv | 40 ++++
 rtl/axi4lite_dpc_cfg_bank.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi4lite_dpc_cfg_bank.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_dpc_cfg_bank_if.sv
// rtl/axi4lite_dpc_cfg_bank_if.sv - AXI4-Lite bus bundle for the DPC config bank
interface axi4lite_dpc_cfg_bank_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4lite_dpc_cfg_bank.sv
// rtl/axi4lite_dpc_cfg_bank.sv - AXI4-Lite DPC control/status words plus bad-pixel LUT window
// Define DPC_CFG_SHADOW_EN to drive go/table_ready/bp_num from frame_start-committed shadow copies.
module axi4lite_dpc_cfg_bank #(
    parameter int          LUT_DEPTH = 512,
    parameter int          LUT_AW    = 9,
    parameter int          LUT_BASE  = 16,
    parameter int          BP_NUM_W  = 10,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] VERSION   = 32'h0002_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    axi4lite_dpc_cfg_bank_if.slave  s_axi,
    output logic                    go,
    output logic                    table_ready,
    output logic [BP_NUM_W-1:0]     bp_num,
    input  logic                    busy,
    input  logic                    err_pulse,
    input  logic                    frame_start,
    output logic                    lut_wen,
    output logic [LUT_AW-1:0]       lut_waddr,
    output logic [31:0]             lut_wdata,
    output logic [3:0]              lut_wstrb,
    output logic [LUT_AW-1:0]       lut_raddr,
    input  logic [31:0]             lut_rdata
);
    localparam int             IW       = ADDR_W - 2;
    localparam logic [IW-1:0]  LUT_LO   = IW'(LUT_BASE);
    localparam logic [IW-1:0]  LUT_HI   = IW'(LUT_BASE + LUT_DEPTH);
    localparam logic [1:0]     RD_LAST  = 2'(RD_LAT - 1);
    localparam logic [1:0]     OKAY     = 2'b00;
    localparam logic [1:0]     SLVERR   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    function automatic logic is_reg(input logic [IW-1:0] idx);
        return idx < IW'(4);
    endfunction

    function automatic logic is_lut(input logic [IW-1:0] idx);
        return (idx >= LUT_LO) && (idx < LUT_HI);
    endfunction

    function automatic logic [LUT_AW-1:0] lut_index(input logic [IW-1:0] idx);
        return LUT_AW'(idx - LUT_LO);
    endfunction

    w_state_t          w_state, w_next;
    logic              aw_held, aw_held_n, w_held, w_held_n;
    logic [IW-1:0]     aw_idx_q, aw_idx_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [3:0]        wstrb_q, wstrb_n;
    logic              awready_q, awready_n, wready_q, wready_n;
    logic              bvalid_q, bvalid_n;
    logic [1:0]        bresp_q, bresp_n;

    r_state_t          r_state, r_next;
    logic [1:0]        rd_cnt, rd_cnt_n;
    logic [LUT_AW-1:0] raddr_q, raddr_n;
    logic [31:0]       rdata_q, rdata_n;
    logic [1:0]        rresp_q, rresp_n;
    logic              rvalid_q, rvalid_n, arready_q, arready_n;

    logic [31:0]       reg0, reg0_n, reg1, reg1_n, reg_rdata;
    logic              err_sticky, err_n, w1c;
    logic              w_exec;
    logic [IW-1:0]     ar_idx;

    assign ar_idx = s_axi.araddr[ADDR_W-1:2];
    assign w_exec = (w_state == W_EXEC);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            r_state   <= R_IDLE;
            rd_cnt    <= '0;
            raddr_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            w_state   <= w_next;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            aw_idx_q  <= aw_idx_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            r_state   <= r_next;
            rd_cnt    <= rd_cnt_n;
            raddr_q   <= raddr_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
            rvalid_q  <= rvalid_n;
            arready_q <= arready_n;
        end
    end

    // Ready flags are registered from the next state, so they are low in reset and drop the
    // cycle after their own handshake.
    always_comb begin
        w_next    = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        aw_idx_n  = aw_idx_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        unique case (w_state)
            W_IDLE: begin
                if (s_axi.awvalid && awready_q) begin
                    aw_held_n = 1'b1;
                    aw_idx_n  = s_axi.awaddr[ADDR_W-1:2];
                end
                if (s_axi.wvalid && wready_q) begin
                    w_held_n = 1'b1;
                    wdata_n  = s_axi.wdata;
                    wstrb_n  = s_axi.wstrb;
                end
                if (aw_held_n && w_held_n) w_next = W_EXEC;
            end
            W_EXEC: begin
                w_next    = W_RESP;
                aw_held_n = 1'b0;
                w_held_n  = 1'b0;
                bvalid_n  = 1'b1;
                bresp_n   = (is_reg(aw_idx_q) || is_lut(aw_idx_q)) ? OKAY : SLVERR;
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_n = 1'b0;
                    w_next   = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
        awready_n = (w_next == W_IDLE) && !aw_held_n;
        wready_n  = (w_next == W_IDLE) && !w_held_n;
    end

    always_comb begin
        unique case (ar_idx[1:0])
            2'd0:    reg_rdata = reg0;
            2'd1:    reg_rdata = reg1;
            2'd2:    reg_rdata = {30'b0, err_sticky, busy};
            default: reg_rdata = VERSION;
        endcase
    end

    always_comb begin
        r_next   = r_state;
        rd_cnt_n = rd_cnt;
        raddr_n  = raddr_q;
        rdata_n  = rdata_q;
        rresp_n  = rresp_q;
        rvalid_n = rvalid_q;
        unique case (r_state)
            R_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    if (is_lut(ar_idx)) begin
                        raddr_n  = lut_index(ar_idx);
                        rd_cnt_n = '0;
                        r_next   = R_WAIT;
                    end else begin
                        r_next   = R_RESP;
                        rvalid_n = 1'b1;
                        rdata_n  = is_reg(ar_idx) ? reg_rdata : 32'h0;
                        rresp_n  = is_reg(ar_idx) ? OKAY : SLVERR;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt == RD_LAST) begin
                    r_next   = R_RESP;
                    rvalid_n = 1'b1;
                    rdata_n  = lut_rdata;
                    rresp_n  = OKAY;
                end else begin
                    rd_cnt_n = rd_cnt + 2'd1;
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    rvalid_n = 1'b0;
                    r_next   = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
        arready_n = (r_next == R_IDLE);
    end

    always_comb begin
        reg0_n = reg0;
        reg1_n = reg1;
        for (int b = 0; b < 4; b++) begin
            if (w_exec && wstrb_q[b] && aw_idx_q == IW'(0)) reg0_n[8*b +: 8] = wdata_q[8*b +: 8];
            if (w_exec && wstrb_q[b] && aw_idx_q == IW'(1)) reg1_n[8*b +: 8] = wdata_q[8*b +: 8];
        end
        w1c   = w_exec && (aw_idx_q == IW'(2)) && wstrb_q[0] && wdata_q[1];
        // A new error event in the clearing cycle must not be lost.
        err_n = err_pulse | (err_sticky & ~w1c);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            reg0       <= '0;
            reg1       <= '0;
            err_sticky <= 1'b0;
        end else begin
            reg0       <= reg0_n;
            reg1       <= reg1_n;
            err_sticky <= err_n;
        end
    end

`ifdef DPC_CFG_SHADOW_EN
    logic [1:0]          sh_ctrl;
    logic [BP_NUM_W-1:0] sh_bp;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sh_ctrl <= '0;
            sh_bp   <= '0;
        end else if (frame_start) begin
            sh_ctrl <= reg0_n[1:0];
            sh_bp   <= reg1_n[BP_NUM_W-1:0];
        end
    end

    assign go          = sh_ctrl[0];
    assign table_ready = sh_ctrl[1];
    assign bp_num      = sh_bp;
`else
    assign go          = reg0[0];
    assign table_ready = reg0[1];
    assign bp_num      = reg1[BP_NUM_W-1:0];
`endif

    assign lut_wen   = w_exec && is_lut(aw_idx_q);
    assign lut_waddr = lut_wen ? lut_index(aw_idx_q) : '0;
    assign lut_wdata = lut_wen ? wdata_q : 32'h0;
    assign lut_wstrb = lut_wen ? wstrb_q : 4'h0;
    assign lut_raddr = raddr_q;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4lite_dpc_cfg_bank.sv
// tb/tb_axi4lite_dpc_cfg_bank.sv - directed and randomized bench for axi4lite_dpc_cfg_bank
module tb_axi4lite_dpc_cfg_bank;
    localparam int          LUT_DEPTH = 512;
    localparam int          LUT_AW    = 9;
    localparam int          LUT_BASE  = 16;
    localparam int          BP_NUM_W  = 10;
    localparam int          RD_LAT    = 2;
    localparam logic [31:0] VERSION   = 32'h0002_0000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                go, table_ready, busy, err_pulse, frame_start;
    logic [BP_NUM_W-1:0] bp_num;
    logic                lut_wen;
    logic [LUT_AW-1:0]   lut_waddr, lut_raddr;
    logic [31:0]         lut_wdata, lut_rdata;
    logic [3:0]          lut_wstrb;

    axi4lite_dpc_cfg_bank_if #(.ADDR_W(32)) axi ();

    axi4lite_dpc_cfg_bank #(
        .LUT_DEPTH(LUT_DEPTH), .LUT_AW(LUT_AW), .LUT_BASE(LUT_BASE), .BP_NUM_W(BP_NUM_W),
        .RD_LAT(RD_LAT), .VERSION(VERSION), .ADDR_W(32)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(axi),
        .go(go), .table_ready(table_ready), .bp_num(bp_num),
        .busy(busy), .err_pulse(err_pulse), .frame_start(frame_start),
        .lut_wen(lut_wen), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_wstrb(lut_wstrb),
        .lut_raddr(lut_raddr), .lut_rdata(lut_rdata)
    );

    always #5 clk = ~clk;

    // Bad-pixel RAM seen by the DUT: RD_LAT-1 output register stages after an asynchronous read.
    bit [31:0] ram [0:LUT_DEPTH-1];
    bit [31:0] rd_pipe [0:3];
    always @(posedge clk) begin
        if (lut_wen)
            for (int b = 0; b < 4; b++)
                if (lut_wstrb[b]) ram[lut_waddr][8*b +: 8] <= lut_wdata[8*b +: 8];
        rd_pipe[0] <= ram[lut_raddr];
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign lut_rdata = rd_pipe[RD_LAT-2];

    int          wen_cnt = 0;
    logic [31:0] last_waddr, last_wdata, last_wstrb;
    always @(negedge clk) begin
        if (lut_wen) begin
            wen_cnt    <= wen_cnt + 1;
            last_waddr <= 32'(lut_waddr);
            last_wdata <= lut_wdata;
            last_wstrb <= 32'(lut_wstrb);
        end
    end

    // Reference model
    logic [31:0] m_reg0 = 0, m_reg1 = 0;
    logic        m_err = 0;
    bit   [31:0] m_lut [0:LUT_DEPTH-1];
    logic [1:0]  m_sh_ctrl = 0;
    logic [9:0]  m_sh_bp = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit lut_word(input logic [31:0] addr);
        int w = int'(addr[31:2]);
        return (w >= LUT_BASE) && (w < LUT_BASE + LUT_DEPTH);
    endfunction

    function automatic logic [1:0] model_wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        int w = int'(addr[31:2]);
        if (w == 0) m_reg0 = merge(m_reg0, d, s);
        else if (w == 1) m_reg1 = merge(m_reg1, d, s);
        else if (w == 2) begin
            if (s[0] && d[1]) m_err = 1'b0;
        end else if (w == 3) begin
        end else if (lut_word(addr)) m_lut[w - LUT_BASE] = merge(m_lut[w - LUT_BASE], d, s);
        else return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        int w = int'(addr[31:2]);
        if (w == 0) return m_reg0;
        if (w == 1) return m_reg1;
        if (w == 2) return {30'b0, m_err, busy};
        if (w == 3) return VERSION;
        if (lut_word(addr)) return m_lut[w - LUT_BASE];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_outs();
`ifdef DPC_CFG_SHADOW_EN
        return {20'b0, m_sh_bp, m_sh_ctrl};
`else
        return {20'b0, m_reg1[9:0], m_reg0[1:0]};
`endif
    endfunction

    task automatic wr_issue(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input bit pulse_exec);
        bit   aw_done = 0, w_done = 0;
        logic awr, wr;
        int   t = 0;
        while (!(aw_done && w_done) && t < 50) begin
            axi.awaddr  = addr;
            axi.wdata   = d;
            axi.wstrb   = s;
            axi.awvalid = !aw_done && (t >= ((lead > 0) ? lead : 0));
            axi.wvalid  = !w_done && (t >= ((lead < 0) ? -lead : 0));
            awr = axi.awready;
            wr  = axi.wready;
            @(posedge clk);
            if (axi.awvalid && awr) aw_done = 1;
            if (axi.wvalid && wr) w_done = 1;
            @(negedge clk);
            t++;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("aw_w_handshake", {30'b0, aw_done, w_done}, 32'h3);
        err_pulse = pulse_exec;
        @(negedge clk);
        err_pulse = 1'b0;
    endtask

    task automatic wait_bvalid();
        int t = 0;
        while (!axi.bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bvalid_seen", {31'b0, axi.bvalid}, 32'h1);
    endtask

    task automatic wr_resp(input int hold, output logic [1:0] resp);
        wait_bvalid();
        for (int i = 0; i < hold; i++) begin
            check("bvalid_hold", {31'b0, axi.bvalid}, 32'h1);
            check("aw_w_blocked", {30'b0, axi.awready, axi.wready}, 32'h0);
            @(negedge clk);
        end
        resp = axi.bresp;
        axi.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi.bready = 1'b0;
        check("bvalid_drop", {31'b0, axi.bvalid}, 32'h0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] s, input int lead, input bit pulse, input int hold);
        int         c0 = wen_cnt;
        bit         hit = lut_word(addr);
        logic [1:0] er, resp;
        er = model_wr(addr, d, s);
        if (pulse) m_err = 1'b1;
        wr_issue(addr, d, s, lead, pulse);
        wr_resp(hold, resp);
        check({tag, "_bresp"}, 32'(resp), 32'(er));
        check({tag, "_wen_cnt"}, 32'(wen_cnt - c0), 32'(hit));
        if (hit) begin
            check({tag, "_waddr"}, last_waddr, 32'(int'(addr[31:2]) - LUT_BASE));
            check({tag, "_wdata"}, last_wdata, d);
            check({tag, "_wstrb"}, last_wstrb, 32'(s));
        end
        check({tag, "_outs"}, {20'b0, bp_num, table_ready, go}, exp_outs());
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input int hold);
        int          t = 0, lat;
        logic [31:0] ed = model_rdata(addr);
        bit          hit = lut_word(addr);
        logic [1:0]  er = (int'(addr[31:2]) < 4 || hit) ? 2'b00 : 2'b10;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        while (!axi.arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_arready"}, {31'b0, axi.arready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        axi.arvalid = 1'b0;
        lat = 1;
        while (!axi.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), hit ? 32'(1 + RD_LAT) : 32'h1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_rvalid_hold"}, {31'b0, axi.rvalid}, 32'h1);
            check({tag, "_rdata_hold"}, axi.rdata, ed);
            check({tag, "_ar_blocked"}, {31'b0, axi.arready}, 32'h0);
        end
        check({tag, "_rdata"}, axi.rdata, ed);
        check({tag, "_rresp"}, 32'(axi.rresp), 32'(er));
        axi.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] a, d;
        int          c0, cat;

        rst_n = 1'b0;
        busy = 0; err_pulse = 0; frame_start = 0;
        axi.awaddr = 0; axi.awprot = 0; axi.awvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = 0; axi.arprot = 0; axi.arvalid = 0; axi.rready = 0;
        repeat (2) @(negedge clk);
        check("rst_readies", {29'b0, axi.awready, axi.wready, axi.arready}, 32'h0);
        check("rst_valids", {30'b0, axi.bvalid, axi.rvalid}, 32'h0);
        check("rst_resps", {28'b0, axi.bresp, axi.rresp}, 32'h0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_outs", {20'b0, bp_num, table_ready, go}, 32'h0);
        check("rst_lut", {lut_wen, lut_wstrb, lut_waddr, lut_raddr}, 32'h0);
        check("rst_lut_wdata", lut_wdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_write("w_first", 32'h4, 32'h1FF, 4'hF, 3, 0, 0);
        do_write("aw_first", 32'h0, 32'h8000_0003, 4'h9, -2, 0, 0);
        do_read("reg0_rd", 32'h0, 0);
        do_write("lut_0x44", 32'h44, 32'hA5A5_0102, 4'h3, 0, 0, 0);
        do_read("lut_0x44_rd", 32'h44, 0);
        do_write("err_0x4000", 32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read("err_0x4000_rd", 32'h4000, 0);
        do_write("lut_last", 32'h83C, 32'h1234_5678, 4'hF, 1, 0, 0);
        do_read("lut_last_rd", 32'h83C, 0);
        do_write("lut_past", 32'h840, 32'h1, 4'hF, 0, 0, 0);
        do_read("lut_past_rd", 32'h840, 0);
        do_read("gap_lo_rd", 32'h10, 0);
        do_read("gap_hi_rd", 32'h3C, 0);
        do_read("lut_first_rd", 32'h40, 0);
        do_read("version_rd", 32'hC, 0);
        do_write("version_wr", 32'hC, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read("version_rd2", 32'hC, 0);

        @(negedge clk); err_pulse = 1'b1; m_err = 1'b1;
        @(negedge clk); err_pulse = 1'b0;
        do_read("err_set_rd", 32'h8, 0);
        do_write("err_w1c", 32'h8, 32'h2, 4'h1, 0, 0, 0);
        do_read("err_clr_rd", 32'h8, 0);
        do_write("err_w1c_vs_set", 32'h8, 32'h2, 4'h1, 0, 1, 0);
        do_read("err_set_wins_rd", 32'h8, 0);
        busy = 1'b1;
        do_read("busy_rd", 32'h8, 0);
        busy = 1'b0;

        do_write("bready_hold", 32'h4, 32'h0000_0155, 4'h3, 0, 0, 10);
        do_read("rready_hold", 32'h4, 10);

        for (int i = 0; i < 60; i++) begin
            cat = $urandom_range(0, 5);
            if (cat < 4) a = 32'(cat * 4);
            else if (cat == 4) a = 32'(($urandom_range(0, LUT_DEPTH - 1) + LUT_BASE) * 4);
            else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(4, LUT_BASE - 1) * 4);
            else a = 32'($urandom_range(LUT_BASE + LUT_DEPTH, 4000) * 4);
            a = a | 32'($urandom_range(0, 3));
            d = $urandom;
            busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                do_write("rnd_wr", a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, 0, 0);
            else
                do_read("rnd_rd", a, 0);
        end
        busy = 1'b0;

        // Reset while the write response is pending.
        do_write("pre_rst_bp", 32'h4, 32'h2AA, 4'hF, 0, 0, 0);
        c0 = wen_cnt;
        void'(model_wr(32'h0, 32'h3, 4'hF));
        wr_issue(32'h0, 32'h3, 4'hF, 0, 0);
        wait_bvalid();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bvalid", {31'b0, axi.bvalid}, 32'h0);
        check("rst_mid_outs", {20'b0, bp_num, table_ready, go}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reg0 = 0; m_reg1 = 0; m_err = 0; m_sh_ctrl = 0; m_sh_bp = 0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_wen", 32'(wen_cnt - c0), 32'h0);
        check("rst_mid_ready", {30'b0, axi.awready, axi.wready}, 32'h3);
        do_read("rst_mid_reg0_rd", 32'h0, 0);

`ifdef DPC_CFG_SHADOW_EN
        do_write("sh_reg0", 32'h0, 32'h1, 4'hF, 0, 0, 0);
        check("sh_go_before", {31'b0, go}, 32'h0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        m_sh_ctrl = m_reg0[1:0];
        m_sh_bp = m_reg1[9:0];
        check("sh_go_after", {31'b0, go}, 32'h1);
        do_read("sh_live_rd", 32'h0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
